div_ctrl: RTL and testbench
===========================

DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 Parameter DIV_MAX_LAT, default 64, SHALL set the maximum cycles to wait for div_done per operation before a timeout.
REQ-002 sys_clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-004 req_valid  in  1  SHALL signal a divide request from EX.
REQ-005 req_unsign  in  1  SHALL select unsigned (1) or signed (0) division.
REQ-006 req_dividend, req_divisor  in  32 each  SHALL carry the operands.
REQ-007 req_ready  out  1  SHALL be high only in IDLE.
REQ-008 flush  in  1  SHALL abort any in-flight operation.
REQ-009 div_enable, div_unsign, div_mod  out  1 each  SHALL drive the divider wrapper.
REQ-010 div_dividend, div_divisor  out  32 each  SHALL present the latched operands.
REQ-011 div_result  in  32  and  div_done  in  1  SHALL return the divider output.
REQ-012 resp_valid  out  1,  resp_lo  out  32 (quotient),  resp_hi  out  32 (remainder)  SHALL deliver HI/LO results.
REQ-013 stall  out  1  SHALL be high whenever state is not IDLE.
REQ-014 err_timeout  out  1  SHALL be a one-cycle pulse on watchdog expiry.

Function
REQ-015 States SHALL be IDLE, RUN_Q, GAP, RUN_R, RESP.
REQ-016 IDLE: on req_valid high and flush low, operands and req_unsign SHALL be latched and state SHALL go to RUN_Q.
REQ-017 RUN_Q: div_enable=1, div_mod=0; on div_done, div_result SHALL be captured into resp_lo and state SHALL go to GAP.
REQ-018 GAP: div_enable=0 for exactly one cycle, then RUN_R.
REQ-019 RUN_R: div_enable=1, div_mod=1; on div_done, div_result SHALL be captured into resp_hi and state SHALL go to RESP.
REQ-020 RESP: resp_valid SHALL be high for exactly one cycle, then IDLE; resp_hi/resp_lo SHALL hold until the next capture.
REQ-021 div_dividend/div_divisor/div_unsign SHALL be stable from RUN_Q through RUN_R.
REQ-022 A watchdog counter SHALL clear on entry to RUN_Q and RUN_R and count in those states; on reaching DIV_MAX_LAT without div_done, it SHALL pulse err_timeout, return to IDLE and suppress resp_valid.
REQ-023 flush SHALL take priority over every transition; the next state SHALL be IDLE with div_enable low, and no resp_valid for the aborted operation.
REQ-024 div_done seen in IDLE, GAP or RESP SHALL be ignored.
REQ-025 Back-to-back requests SHALL be accepted no earlier than the cycle after RESP.

Reset
REQ-026 When rst_n is low: state=IDLE, req_ready=1, stall=0, div_enable=0, div_mod=0, div_unsign=0, operand registers=0, resp_valid=0, resp_hi=resp_lo=0, err_timeout=0, watchdog=0.
REQ-027 Reset mid-operation SHALL discard the operation with no response.

Configuration
REQ-028 With DIV_ZERO_FAST_EN defined, a request with divisor 0 SHALL bypass the divider: IDLE->RESP directly, resp_lo=32'hFFFFFFFF, resp_hi=dividend, div_enable never asserted.
REQ-029 Without DIV_ZERO_FAST_EN, divisor 0 SHALL follow the normal RUN_Q/GAP/RUN_R path, and the results SHALL be whatever the divider returns.

Structure
REQ-030 The state encoding and a DIV_MAX_LAT_DEFAULT constant SHALL live in shared package div_pkg.
REQ-031 The watchdog SHALL be a sub-module div_watchdog (clear, count-enable, expire).

Verification
REQ-032 Signed 100/7 -> resp_lo=14, resp_hi=2, one resp_valid pulse, stall high throughout.
REQ-033 Signed -7/2 -> resp_lo=32'hFFFFFFFD, resp_hi=32'hFFFFFFFF; unsigned 32'hFFFFFFFF/2 -> resp_lo=32'h7FFFFFFF, resp_hi=1.
REQ-034 Divisor 0, dividend 5, macro on -> resp_valid one cycle after accept, resp_lo=32'hFFFFFFFF, resp_hi=5, div_enable never high.
REQ-035 flush asserted during RUN_R -> IDLE next cycle, div_enable low, no resp_valid; a following 9/3 request -> resp_lo=3, resp_hi=0.
REQ-036 Divider model never asserts div_done -> err_timeout pulses 64 cycles after RUN_Q entry, state IDLE, resp_valid stays low.
REQ-037 rst_n low during RUN_Q -> all outputs at reset values asynchronously; no response after release.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the divide controller: FSM state encoding,
// the default watchdog limit and a small state helper.
package div_pkg;

    localparam int DIV_MAX_LAT_DEFAULT = 64;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RUN_Q = 3'd1;
    localparam logic [2:0] ST_GAP   = 3'd2;
    localparam logic [2:0] ST_RUN_R = 3'd3;
    localparam logic [2:0] ST_RESP  = 3'd4;

    // True in the two states where the divider is busy on our behalf
    function automatic logic is_running(input logic [2:0] st);
        return (st == ST_RUN_Q) || (st == ST_RUN_R);
    endfunction

endpackage

// File: rtl/div_watchdog.sv
// Cycle watchdog for one divider pass: cleared when a pass starts,
// counts while the pass runs, flags expiry on its MAX_LAT-th cycle.
module div_watchdog
    import div_pkg::*;
#(
    parameter int MAX_LAT = DIV_MAX_LAT_DEFAULT
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    output logic expire
);

    localparam int CW = $clog2(MAX_LAT + 1);

    logic [CW-1:0] cnt;

    // Count the cycles spent in the current pass; a new pass restarts at zero
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (count_en) begin
            cnt <= cnt + CW'(1);
        end
    end

    // The pass has used its whole budget once this is its last allowed cycle
    always_comb begin
        expire = count_en && (cnt == CW'(MAX_LAT - 1));
    end

endmodule

// File: rtl/div_ctrl.sv
// Divide controller: sequences a shared divider twice per request
// (quotient, then remainder) and returns the pair as LO/HI.
// Optional feature macro: DIV_ZERO_FAST_EN -- a zero divisor skips the
// divider and answers immediately with LO = all ones, HI = dividend.
module div_ctrl
    import div_pkg::*;
#(
    parameter int DIV_MAX_LAT = DIV_MAX_LAT_DEFAULT
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_unsign,
    input  logic [31:0] req_dividend,
    input  logic [31:0] req_divisor,
    output logic        req_ready,
    input  logic        flush,
    output logic        div_enable,
    output logic        div_unsign,
    output logic        div_mod,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divisor,
    input  logic [31:0] div_result,
    input  logic        div_done,
    output logic        resp_valid,
    output logic [31:0] resp_lo,
    output logic [31:0] resp_hi,
    output logic        stall,
    output logic        err_timeout
);

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic       accept;
    logic       zero_fast;
    logic       timeout_hit;
    logic       wd_clear;
    logic       wd_count_en;
    logic       wd_expire;

`ifdef DIV_ZERO_FAST_EN
    assign zero_fast = (req_divisor == 32'd0);
`else
    assign zero_fast = 1'b0;
`endif

    assign accept      = (state == ST_IDLE) && req_valid && !flush;
    assign wd_count_en = is_running(state);
    assign wd_clear    = ((state_nxt == ST_RUN_Q) && (state != ST_RUN_Q)) ||
                         ((state_nxt == ST_RUN_R) && (state != ST_RUN_R));

    div_watchdog #(
        .MAX_LAT (DIV_MAX_LAT)
    ) u_watchdog (
        .sys_clk  (sys_clk),
        .rst_n    (rst_n),
        .clear    (wd_clear),
        .count_en (wd_count_en),
        .expire   (wd_expire)
    );

    // Next-state logic; flush overrides everything, done beats a same-cycle timeout
    always_comb begin
        state_nxt   = state;
        timeout_hit = 1'b0;
        if (flush) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        state_nxt = zero_fast ? ST_RESP : ST_RUN_Q;
                    end
                end
                ST_RUN_Q: begin
                    if (div_done) begin
                        state_nxt = ST_GAP;
                    end else if (wd_expire) begin
                        state_nxt   = ST_IDLE;
                        timeout_hit = 1'b1;
                    end
                end
                ST_GAP: begin
                    state_nxt = ST_RUN_R;
                end
                ST_RUN_R: begin
                    if (div_done) begin
                        state_nxt = ST_RESP;
                    end else if (wd_expire) begin
                        state_nxt   = ST_IDLE;
                        timeout_hit = 1'b1;
                    end
                end
                ST_RESP: begin
                    state_nxt = ST_IDLE;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State register and the registered one-cycle timeout pulse
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            err_timeout <= timeout_hit;
        end
    end

    // Latch the operands once at acceptance so the divider sees them steady
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            div_dividend <= '0;
            div_divisor  <= '0;
            div_unsign   <= 1'b0;
        end else if (accept) begin
            div_dividend <= req_dividend;
            div_divisor  <= req_divisor;
            div_unsign   <= req_unsign;
        end
    end

    // Capture quotient and remainder as each pass completes; held until overwritten
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_lo <= '0;
            resp_hi <= '0;
        end else if (!flush) begin
            if (accept && zero_fast) begin
                resp_lo <= 32'hFFFF_FFFF;
                resp_hi <= req_dividend;
            end else if ((state == ST_RUN_Q) && div_done) begin
                resp_lo <= div_result;
            end else if ((state == ST_RUN_R) && div_done) begin
                resp_hi <= div_result;
            end
        end
    end

    assign req_ready  = (state == ST_IDLE);
    assign stall      = (state != ST_IDLE);
    assign div_enable = is_running(state);
    assign div_mod    = (state == ST_RUN_R);
    assign resp_valid = (state == ST_RESP) && !flush;

endmodule

// File: tb/tb_div_ctrl.sv
// Testbench for div_ctrl with a behavioural divider of configurable latency.
// Honours DIV_ZERO_FAST_EN the same way the design does.
module tb_div_ctrl;

    logic        sys_clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_unsign;
    logic [31:0] req_dividend;
    logic [31:0] req_divisor;
    logic        req_ready;
    logic        flush;
    logic        div_enable;
    logic        div_unsign;
    logic        div_mod;
    logic [31:0] div_dividend;
    logic [31:0] div_divisor;
    logic [31:0] div_result;
    logic        div_done;
    logic        resp_valid;
    logic [31:0] resp_lo;
    logic [31:0] resp_hi;
    logic        stall;
    logic        err_timeout;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 sys_clk = ~sys_clk;

    div_ctrl dut (
        .sys_clk      (sys_clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_unsign   (req_unsign),
        .req_dividend (req_dividend),
        .req_divisor  (req_divisor),
        .req_ready    (req_ready),
        .flush        (flush),
        .div_enable   (div_enable),
        .div_unsign   (div_unsign),
        .div_mod      (div_mod),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_result   (div_result),
        .div_done     (div_done),
        .resp_valid   (resp_valid),
        .resp_lo      (resp_lo),
        .resp_hi      (resp_hi),
        .stall        (stall),
        .err_timeout  (err_timeout)
    );

    // Behavioural divider: answers model_lat cycles into an enabled pass
    int          model_lat   = 2;
    bit          model_hang  = 1'b0;
    logic        inject_done = 1'b0;
    int          model_cnt;
    logic        model_done;
    logic [31:0] model_result;

    function automatic logic [31:0] divide(input logic u, input logic m,
                                           input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return m ? a : 32'hFFFF_FFFF;
        if (u) return m ? (a % b) : (a / b);
        return m ? 32'(sa % sb) : 32'(sa / sb);
    endfunction

    always @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            model_cnt    <= 0;
            model_done   <= 1'b0;
            model_result <= '0;
        end else if (!div_enable) begin
            model_cnt  <= 0;
            model_done <= 1'b0;
        end else begin
            model_cnt <= model_cnt + 1;
            if (!model_hang && (model_cnt + 1 == model_lat)) begin
                model_done   <= 1'b1;
                model_result <= divide(div_unsign, div_mod, div_dividend, div_divisor);
            end else begin
                model_done <= 1'b0;
            end
        end
    end

    assign div_done   = model_done | inject_done;
    assign div_result = model_result;

    typedef struct {
        string       name;
        logic        u;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
    } vec_t;

    vec_t vecs[7];

    // Compare one observed value against its expected value
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Issue one request and follow it to its response (bounded wait)
    task automatic applyStimulus(input logic u, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] lo, output logic [31:0] hi,
                                 output int pulses, output logic stall_ok,
                                 output logic stable_ok, output logic en_seen,
                                 output int lat);
        @(negedge sys_clk);
        req_valid    = 1'b1;
        req_unsign   = u;
        req_dividend = a;
        req_divisor  = b;
        @(negedge sys_clk);
        req_valid = 1'b0;
        stall_ok  = 1'b1;
        stable_ok = 1'b1;
        en_seen   = 1'b0;
        pulses    = 0;
        lo        = '0;
        hi        = '0;
        lat       = 0;
        while (!resp_valid && lat < 300) begin
            if (!stall) stall_ok = 1'b0;
            if (div_enable) en_seen = 1'b1;
            if (div_dividend !== a || div_divisor !== b || div_unsign !== u) stable_ok = 1'b0;
            @(negedge sys_clk);
            lat++;
        end
        if (resp_valid) begin
            pulses = 1;
            lo     = resp_lo;
            hi     = resp_hi;
            if (!stall) stall_ok = 1'b0;
            for (int k = 0; k < 3; k++) begin
                @(negedge sys_clk);
                if (resp_valid) pulses++;
            end
        end
    endtask

    logic [31:0] got_lo;
    logic [31:0] got_hi;
    int          got_pulses;
    logic        got_stall_ok;
    logic        got_stable_ok;
    logic        got_en_seen;
    int          got_lat;
    int          wait_cnt;
    logic        saw_resp;

    initial begin
        vecs[0] = '{"s100/7",   1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
        vecs[1] = '{"s-7/2",    1'b0, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF};
        vecs[2] = '{"uFFFF/2",  1'b1, 32'hFFFF_FFFF,  32'd2,          32'h7FFF_FFFF,  32'd1};
        vecs[3] = '{"u1000/10", 1'b1, 32'd1000,       32'd10,         32'd100,        32'd0};
        vecs[4] = '{"s7/-2",    1'b0, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1};
        vecs[5] = '{"u5/7",     1'b1, 32'd5,          32'd7,          32'd0,          32'd5};
        vecs[6] = '{"s-100/7",  1'b0, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE};

        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_unsign   = 1'b0;
        req_dividend = '0;
        req_divisor  = '0;
        flush        = 1'b0;
        #2;
        checkOutput("rst req_ready",   32'(req_ready),   32'd1);
        checkOutput("rst stall",       32'(stall),       32'd0);
        checkOutput("rst div_enable",  32'(div_enable),  32'd0);
        checkOutput("rst div_mod",     32'(div_mod),     32'd0);
        checkOutput("rst resp_valid",  32'(resp_valid),  32'd0);
        checkOutput("rst err_timeout", 32'(err_timeout), 32'd0);
        checkOutput("rst resp_lo",     resp_lo,          32'd0);
        @(negedge sys_clk);
        @(negedge sys_clk);
        rst_n = 1'b1;
        @(negedge sys_clk);

        // A stray div_done while idle must not start or complete anything
        inject_done = 1'b1;
        @(negedge sys_clk);
        inject_done = 1'b0;
        checkOutput("idle done stall",      32'(stall),      32'd0);
        checkOutput("idle done resp_valid", 32'(resp_valid), 32'd0);

        foreach (vecs[i]) begin
            model_lat = 1 + (i % 3);
            applyStimulus(vecs[i].u, vecs[i].a, vecs[i].b, got_lo, got_hi,
                          got_pulses, got_stall_ok, got_stable_ok, got_en_seen, got_lat);
            checkOutput({vecs[i].name, " lo"},     got_lo,               vecs[i].lo);
            checkOutput({vecs[i].name, " hi"},     got_hi,               vecs[i].hi);
            checkOutput({vecs[i].name, " pulses"}, 32'(got_pulses),      32'd1);
            checkOutput({vecs[i].name, " stall"},  32'(got_stall_ok),    32'd1);
            checkOutput({vecs[i].name, " stable"}, 32'(got_stable_ok),   32'd1);
        end

        // Divisor zero: fast path when enabled, otherwise through the divider
        model_lat = 2;
        applyStimulus(1'b0, 32'd5, 32'd0, got_lo, got_hi,
                      got_pulses, got_stall_ok, got_stable_ok, got_en_seen, got_lat);
        checkOutput("div0 lo",     got_lo,          32'hFFFF_FFFF);
        checkOutput("div0 hi",     got_hi,          32'd5);
        checkOutput("div0 pulses", 32'(got_pulses), 32'd1);
`ifdef DIV_ZERO_FAST_EN
        checkOutput("div0 enable seen", 32'(got_en_seen), 32'd0);
        checkOutput("div0 latency",     32'(got_lat),     32'd0);
`else
        checkOutput("div0 enable seen", 32'(got_en_seen), 32'd1);
`endif

        // Flush during the remainder pass aborts without a response
        model_lat = 3;
        @(negedge sys_clk);
        req_valid    = 1'b1;
        req_unsign   = 1'b0;
        req_dividend = 32'd50;
        req_divisor  = 32'd6;
        @(negedge sys_clk);
        req_valid = 1'b0;
        wait_cnt  = 0;
        while (!(div_enable && div_mod) && wait_cnt < 100) begin
            @(negedge sys_clk);
            wait_cnt++;
        end
        checkOutput("flush reached RUN_R", 32'(div_enable && div_mod), 32'd1);
        flush = 1'b1;
        @(negedge sys_clk);
        flush = 1'b0;
        checkOutput("flush div_enable", 32'(div_enable), 32'd0);
        checkOutput("flush req_ready",  32'(req_ready),  32'd1);
        saw_resp = resp_valid;
        for (int k = 0; k < 4; k++) begin
            @(negedge sys_clk);
            if (resp_valid) saw_resp = 1'b1;
        end
        checkOutput("flush no resp", 32'(saw_resp), 32'd0);
        applyStimulus(1'b0, 32'd9, 32'd3, got_lo, got_hi,
                      got_pulses, got_stall_ok, got_stable_ok, got_en_seen, got_lat);
        checkOutput("post-flush lo",     got_lo,          32'd3);
        checkOutput("post-flush hi",     got_hi,          32'd0);
        checkOutput("post-flush pulses", 32'(got_pulses), 32'd1);

        // Divider that never answers: watchdog fires 64 cycles into RUN_Q
        model_hang = 1'b1;
        @(negedge sys_clk);
        req_valid    = 1'b1;
        req_dividend = 32'd77;
        req_divisor  = 32'd4;
        @(negedge sys_clk);
        req_valid = 1'b0;
        wait_cnt  = 0;
        saw_resp  = 1'b0;
        while (!err_timeout && wait_cnt < 200) begin
            if (resp_valid) saw_resp = 1'b1;
            @(negedge sys_clk);
            wait_cnt++;
        end
        checkOutput("timeout latency",   32'(wait_cnt),  32'd64);
        checkOutput("timeout req_ready", 32'(req_ready), 32'd1);
        @(negedge sys_clk);
        if (resp_valid) saw_resp = 1'b1;
        checkOutput("timeout one pulse", 32'(err_timeout), 32'd0);
        checkOutput("timeout no resp",   32'(saw_resp),    32'd0);
        model_hang = 1'b0;

        // Reset in the middle of RUN_Q clears everything at once
        model_lat = 5;
        @(negedge sys_clk);
        req_valid    = 1'b1;
        req_dividend = 32'd81;
        req_divisor  = 32'd9;
        @(negedge sys_clk);
        req_valid = 1'b0;
        checkOutput("pre-reset in RUN_Q", 32'(div_enable && !div_mod), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async rst req_ready",  32'(req_ready),  32'd1);
        checkOutput("async rst stall",      32'(stall),      32'd0);
        checkOutput("async rst div_enable", 32'(div_enable), 32'd0);
        checkOutput("async rst dividend",   div_dividend,    32'd0);
        checkOutput("async rst resp_lo",    resp_lo,         32'd0);
        checkOutput("async rst resp_hi",    resp_hi,         32'd0);
        @(negedge sys_clk);
        rst_n    = 1'b1;
        saw_resp = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge sys_clk);
            if (resp_valid || stall) saw_resp = 1'b1;
        end
        checkOutput("post-reset quiet", 32'(saw_resp), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
